// File: rtl/alu_req_arbiter_if.sv
// Signal bundle between execute-stage requesters, alu_req_arbiter and the shared ALU.
// slave = arbiter side, master = requester/ALU environment side.
interface alu_req_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned GW      = 2
) ();
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [64*NUM_REQ-1:0] req_a;
    logic [64*NUM_REQ-1:0] req_b;
    logic [6*NUM_REQ-1:0]  req_shamt;
    logic [4*NUM_REQ-1:0]  req_ctrl;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [63:0]           resp_data;
    logic                  resp_err;
    logic [63:0]           alu_a;
    logic [63:0]           alu_b;
    logic [5:0]            alu_shamt;
    logic [3:0]            alu_ctrl;
    logic [63:0]           alu_z;
    logic                  busy;
    logic [GW-1:0]         grant_id;

    modport slave (
        input  req_valid, req_a, req_b, req_shamt, req_ctrl, resp_ready, alu_z,
        output req_ready, resp_valid, resp_data, resp_err,
        output alu_a, alu_b, alu_shamt, alu_ctrl, busy, grant_id
    );

    modport master (
        output req_valid, req_a, req_b, req_shamt, req_ctrl, resp_ready, alu_z,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  alu_a, alu_b, alu_shamt, alu_ctrl, busy, grant_id
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin sharing of one registered 64-bit ALU between NUM_REQ requesters.
// Optional macro ALU_OPCHECK_EN: illegal opcodes bypass the ALU and answer with resp_err=1.
module alu_req_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned GW      = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    alu_req_arbiter_if.slave bus
);
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 6;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

    state_e             state_q, state_d;
    logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [DW-1:0]      alu_a_q, alu_a_d;
    logic [DW-1:0]      alu_b_q, alu_b_d;
    logic [SW-1:0]      alu_shamt_q, alu_shamt_d;
    logic [CW-1:0]      alu_ctrl_q, alu_ctrl_d;
    logic [DW-1:0]      resp_data_q, resp_data_d;
    logic               resp_err_q, resp_err_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic               busy_q, busy_d;

    logic               pick_found_c;
    logic [GW-1:0]      pick_c;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [NUM_REQ-1:0] grant_onehot_c;
    logic               owner_ready_c;
    logic [DW-1:0]      sel_a_c, sel_b_c;
    logic [SW-1:0]      sel_shamt_c;
    logic [CW-1:0]      sel_ctrl_c;

`ifdef ALU_OPCHECK_EN
    function automatic logic op_illegal(input logic [CW-1:0] op);
        logic bad;
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0110, 4'b1001, 4'b1100, 4'b1101: bad = 1'b0;
            default:                            bad = 1'b1;
        endcase
        return bad;
    endfunction
`endif

    // Round-robin pick: indices above rr_ptr first, then wrap to 0..rr_ptr.
    always_comb begin
        pick_found_c = 1'b0;
        pick_c       = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!pick_found_c && bus.req_valid[i] && (GW'(i) > rr_ptr_q)) begin
                pick_found_c = 1'b1;
                pick_c       = GW'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!pick_found_c && bus.req_valid[i] && (GW'(i) <= rr_ptr_q)) begin
                pick_found_c = 1'b1;
                pick_c       = GW'(i);
            end
        end
    end

    // Payload mux, ready decode and owner response-ready select.
    always_comb begin
        sel_a_c        = '0;
        sel_b_c        = '0;
        sel_shamt_c    = '0;
        sel_ctrl_c     = '0;
        req_ready_c    = '0;
        grant_onehot_c = '0;
        owner_ready_c  = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick_c == GW'(i)) begin
                sel_a_c     = bus.req_a[i*DW +: DW];
                sel_b_c     = bus.req_b[i*DW +: DW];
                sel_shamt_c = bus.req_shamt[i*SW +: SW];
                sel_ctrl_c  = bus.req_ctrl[i*CW +: CW];
            end
            req_ready_c[i]    = RST_N && (state_q == IDLE) && pick_found_c && (pick_c == GW'(i));
            grant_onehot_c[i] = (grant_q == GW'(i));
            if (grant_q == GW'(i)) begin
                owner_ready_c = bus.resp_ready[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_shamt_d  = alu_shamt_q;
        alu_ctrl_d   = alu_ctrl_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        resp_valid_d = resp_valid_q;
        unique case (state_q)
            IDLE: begin
                if (|req_ready_c) begin
                    rr_ptr_d = pick_c;
                    grant_d  = pick_c;
`ifdef ALU_OPCHECK_EN
                    if (op_illegal(sel_ctrl_c)) begin
                        resp_data_d  = '0;
                        resp_err_d   = 1'b1;
                        resp_valid_d = req_ready_c;
                        state_d      = RESP;
                    end else
`endif
                    begin
                        alu_a_d     = sel_a_c;
                        alu_b_d     = sel_b_c;
                        alu_shamt_d = sel_shamt_c;
                        alu_ctrl_d  = sel_ctrl_c;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                resp_data_d  = bus.alu_z;
                resp_err_d   = 1'b0;
                resp_valid_d = grant_onehot_c;
                state_d      = RESP;
            end
            RESP: begin
                if (owner_ready_c) begin
                    resp_valid_d = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            rr_ptr_q     <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_shamt_q  <= '0;
            alu_ctrl_q   <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_shamt_q  <= alu_shamt_d;
            alu_ctrl_q   <= alu_ctrl_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_shamt  = alu_shamt_q;
    assign bus.alu_ctrl   = alu_ctrl_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_q;
endmodule
